// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and instruction memory, assembles two-word
// (opcode + immediate) instructions and issues one registered instruction per cycle.
module fetch_unit #(
  parameter int           W         = 16,
  parameter int           ADDR_W    = 10,
  parameter logic [W-1:0] RESET_PC  = '0,
  parameter logic [W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              branch_taken_i,
  input  logic [W-1:0]      branch_target_i,
  input  logic              imem_wr_en_i,
  input  logic [ADDR_W-1:0] imem_wr_addr_i,
  input  logic [W-1:0]      imem_wr_data_i,
  output logic [W-1:0]      instr_o,
  output logic [W-1:0]      pc_o,
  output logic [W-1:0]      imm_o,
  output logic              imm_valid_o,
  output logic              valid_o
);

  typedef enum logic {S_OP, S_IMM} state_t;

  logic [W-1:0] mem [2**ADDR_W];

  state_t       state, state_next;
  logic [W-1:0] pc, pc_next;
  logic [W-1:0] op_hold, op_hold_next;
  logic [W-1:0] op_pc, op_pc_next;
  logic [W-1:0] instr, instr_next;
  logic [W-1:0] issue_pc, issue_pc_next;
  logic [W-1:0] imm, imm_next;
  logic         imm_valid, imm_valid_next;
  logic         valid, valid_next;

  logic [W-1:0] word;
  logic         two_word;

  // Read is combinational, so a same-cycle write to the fetched word is seen only next cycle.
  assign word     = mem[pc[ADDR_W-1:0]];
  assign two_word = (word[W-1 -: 3] == 3'b111);

  always_ff @(posedge clk) begin
    if (imem_wr_en_i) begin
      mem[imem_wr_addr_i] <= imem_wr_data_i;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    op_hold_next   = op_hold;
    op_pc_next     = op_pc;
    instr_next     = instr;
    issue_pc_next  = issue_pc;
    imm_next       = imm;
    imm_valid_next = imm_valid;
    valid_next     = valid;

    if (branch_taken_i) begin
      pc_next        = branch_target_i;
      state_next     = S_OP;
      op_hold_next   = '0;
      instr_next     = NOP_INSTR;
      valid_next     = 1'b0;
      imm_valid_next = 1'b0;
    end else if (stall_i) begin
      state_next = state;
    end else if (flush_i) begin
      instr_next     = NOP_INSTR;
      valid_next     = 1'b0;
      imm_valid_next = 1'b0;
    end else begin
      unique case (state)
        S_OP: begin
          pc_next = pc + W'(1);
          if (two_word) begin
            op_hold_next   = word;
            op_pc_next     = pc;
            state_next     = S_IMM;
            instr_next     = NOP_INSTR;
            valid_next     = 1'b0;
            imm_valid_next = 1'b0;
          end else begin
            instr_next     = word;
            issue_pc_next  = pc;
            valid_next     = 1'b1;
            imm_valid_next = 1'b0;
          end
        end
        S_IMM: begin
          pc_next        = pc + W'(1);
          state_next     = S_OP;
          instr_next     = op_hold;
          issue_pc_next  = op_pc;
          imm_next       = word;
          valid_next     = 1'b1;
          imm_valid_next = 1'b1;
        end
        default: state_next = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_OP;
      pc        <= RESET_PC;
      op_hold   <= '0;
      op_pc     <= '0;
      instr     <= NOP_INSTR;
      issue_pc  <= '0;
      imm       <= '0;
      imm_valid <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      op_hold   <= op_hold_next;
      op_pc     <= op_pc_next;
      instr     <= instr_next;
      issue_pc  <= issue_pc_next;
      imm       <= imm_next;
      imm_valid <= imm_valid_next;
      valid     <= valid_next;
    end
  end

  assign instr_o     = instr;
  assign pc_o        = issue_pc;
  assign imm_o       = imm;
  assign imm_valid_o = imm_valid;
  assign valid_o     = valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, two-word assembly, stall/flush,
// branch redirect (incl. over stall and PC wrap) and asynchronous reset mid-instruction.
module tb_fetch_unit;

  localparam int W      = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              branch_taken_i = 1'b0;
  logic [W-1:0]      branch_target_i = '0;
  logic              imem_wr_en_i = 1'b0;
  logic [ADDR_W-1:0] imem_wr_addr_i = '0;
  logic [W-1:0]      imem_wr_data_i = '0;
  logic [W-1:0]      instr_o, pc_o, imm_o;
  logic              imm_valid_o, valid_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.W(W), .ADDR_W(ADDR_W), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_wr_en_i(imem_wr_en_i), .imem_wr_addr_i(imem_wr_addr_i), .imem_wr_data_i(imem_wr_data_i),
    .instr_o(instr_o), .pc_o(pc_o), .imm_o(imm_o), .imm_valid_o(imm_valid_o), .valid_o(valid_o)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic checkIssue(input string tag, input logic [W-1:0] instr, input logic [W-1:0] pc,
                            input logic valid, input logic imm_valid);
    checkOutput({tag, ".instr"}, instr_o, instr);
    checkOutput({tag, ".pc"}, pc_o, pc);
    checkOutput({tag, ".valid"}, W'(valid_o), W'(valid));
    checkOutput({tag, ".imm_valid"}, W'(imm_valid_o), W'(imm_valid));
  endtask

  // One clock edge with the given control inputs; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic stall, input logic flush, input logic branch,
                               input logic [W-1:0] target);
    stall_i         = stall;
    flush_i         = flush;
    branch_taken_i  = branch;
    branch_target_i = target;
    @(posedge clk);
    #1;
    stall_i        = 1'b0;
    flush_i        = 1'b0;
    branch_taken_i = 1'b0;
  endtask

  task automatic loadWord(input logic [ADDR_W-1:0] addr, input logic [W-1:0] data);
    imem_wr_en_i   = 1'b1;
    imem_wr_addr_i = addr;
    imem_wr_data_i = data;
    @(posedge clk);
    #1;
    imem_wr_en_i = 1'b0;
  endtask

  initial begin
    // Reset and one-word issue
    #2;
    rst = 1'b0;
    #1;
    checkIssue("rst.async", 16'h0000, 16'h0000, 1'b0, 1'b0);
    checkOutput("rst.imm", imm_o, 16'h0000);
    loadWord(10'd0, 16'h1234);
    loadWord(10'd1, 16'h0443);
    loadWord(10'd2, 16'h2000);
    checkIssue("rst.held", 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("one.w0", 16'h1234, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("one.w1", 16'h0443, 16'h0001, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("one.w2", 16'h2000, 16'h0002, 1'b1, 1'b0);

    // Two-word assembly
    rst = 1'b0;
    loadWord(10'd0, 16'hE401);
    loadWord(10'd1, 16'h00FF);
    loadWord(10'd2, 16'h1111);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("two.bubble", 16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("two.issue", 16'hE401, 16'h0000, 1'b1, 1'b1);
    checkOutput("two.imm", imm_o, 16'h00FF);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("two.next", 16'h1111, 16'h0002, 1'b1, 1'b0);
    checkOutput("two.imm_hold", imm_o, 16'h00FF);

    // Stall, flush, same-cycle write collision
    rst = 1'b0;
    loadWord(10'd0, 16'h1234);
    loadWord(10'd1, 16'h0443);
    loadWord(10'd2, 16'h2000);
    loadWord(10'd3, 16'h3333);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("sf.pre", 16'h0443, 16'h0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      checkIssue($sformatf("sf.stall%0d", i), 16'h0443, 16'h0001, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkIssue("sf.flush", 16'h0000, 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("sf.refetch", 16'h2000, 16'h0002, 1'b1, 1'b0);
    imem_wr_en_i   = 1'b1;
    imem_wr_addr_i = 10'd3;
    imem_wr_data_i = 16'h3AAA;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    imem_wr_en_i = 1'b0;
    checkIssue("wr.old", 16'h3333, 16'h0003, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0003);
    checkIssue("wr.br", 16'h0000, 16'h0003, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("wr.new", 16'h3AAA, 16'h0003, 1'b1, 1'b0);

    // Branch during the immediate fetch discards the pending opcode
    rst = 1'b0;
    loadWord(10'd4, 16'hE401);
    loadWord(10'd5, 16'h00AA);
    loadWord(10'd16, 16'h5555);
    loadWord(10'd17, 16'h1717);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0004);
    checkOutput("bimm.br4", W'(valid_o), W'(1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("bimm.op", W'(valid_o), W'(1'b0));
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010);
    checkIssue("bimm.kill", 16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("bimm.tgt", 16'h5555, 16'h0010, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("bimm.tgt1", 16'h1717, 16'h0011, 1'b1, 1'b0);

    // Branch beats stall; PC wraps and memory aliases
    rst = 1'b0;
    loadWord(10'd0, 16'h1234);
    loadWord(10'd1023, 16'h4BCD);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("wrap.pre", 16'h1234, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);
    checkIssue("wrap.brstall", 16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("wrap.ffff", 16'h4BCD, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("wrap.zero", 16'h1234, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset while waiting for an immediate
    rst = 1'b0;
    loadWord(10'd8, 16'h1234);
    loadWord(10'd9, 16'hE401);
    loadWord(10'd10, 16'h00FF);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0008);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("arst.pre", 16'h1234, 16'h0008, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    #3;
    rst = 1'b0;
    #1;
    checkIssue("arst.clear", 16'h0000, 16'h0000, 1'b0, 1'b0);
    loadWord(10'd0, 16'h3456);
    loadWord(10'd1, 16'h0777);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("arst.r0", 16'h3456, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIssue("arst.r1", 16'h0777, 16'h0001, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
